// File: rtl/i2c_init_sequencer_if.sv
// Bus bundle between the I2C init sequencer and its table, command FIFO and completion sources.
// master: the sequencer side; slave: the environment (table ROM, I2C master, controller).
interface i2c_init_sequencer_if #(
  parameter int TABLE_ADDR_WIDTH = 8
);
  logic                        start;
  logic [TABLE_ADDR_WIDTH:0]   table_len;
  logic [TABLE_ADDR_WIDTH-1:0] table_addr;
  logic [55:0]                 table_data;
  logic [55:0]                 i2c_fifo_din;
  logic                        i2c_fifo_wr_en;
  logic                        i2c_fifo_full;
  logic                        i2c_wr_data_success;
  logic                        i2c_rdata_valid;
  logic                        busy;
  logic                        done;
  logic                        err;
  logic [TABLE_ADDR_WIDTH:0]   issued_cnt;

  modport master (
    input  start, table_len, table_data, i2c_fifo_full, i2c_wr_data_success, i2c_rdata_valid,
    output table_addr, i2c_fifo_din, i2c_fifo_wr_en, busy, done, err, issued_cnt
  );

  modport slave (
    output start, table_len, table_data, i2c_fifo_full, i2c_wr_data_success, i2c_rdata_valid,
    input  table_addr, i2c_fifo_din, i2c_fifo_wr_en, busy, done, err, issued_cnt
  );
endinterface

// File: rtl/i2c_init_sequencer.sv
// Streams a table of opaque 56-bit I2C command words into the I2C master's command FIFO,
// bounding outstanding transactions and aborting with err if completions stop arriving.
module i2c_init_sequencer #(
  parameter int CLK_FREQ_MHZ     = 100,
  parameter int TABLE_ADDR_WIDTH = 8,
  parameter int MAX_PENDING      = 4,
  parameter int TIMEOUT_US       = 20000
) (
  input  logic                 clk,
  input  logic                 rstn,
  i2c_init_sequencer_if.master bus
);

  localparam int unsigned LIMIT = CLK_FREQ_MHZ * TIMEOUT_US;
  localparam int          TW    = $clog2(LIMIT + 1);
  localparam int          AW    = TABLE_ADDR_WIDTH;

  localparam logic [3:0]    MAX_PEND  = 4'(MAX_PENDING);
  localparam logic [TW-1:0] TIMER_TOP = TW'(LIMIT - 1);
  localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_PUSH, S_DRAIN, S_DONE, S_ERR
  } state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [AW:0]    len_q, len_d;
  logic [AW:0]    issued_q, issued_d;
  logic [3:0]     pending_q, pending_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic           wr_en_q;
  logic [55:0]    din_q, din_d;

  logic           comp, comp_cnt, push, last_entry, timeout;
  logic [3:0]     pend_after_comp;

  // Completions only count inside a sequence and never drive pending below zero.
  assign comp            = bus.i2c_wr_data_success | bus.i2c_rdata_valid;
  assign comp_cnt        = comp && busy_q && (pending_q != '0);
  assign pend_after_comp = pending_q - 4'(comp_cnt);
  assign last_entry      = ({1'b0, idx_q} == (len_q - LEN_ONE));
  assign timeout         = busy_q && (pending_q != '0) && !comp && (timer_q == TIMER_TOP);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    issued_d = issued_q;
    busy_d   = busy_q;
    err_d    = err_q;
    push     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          err_d    = 1'b0;
          issued_d = '0;
          idx_d    = '0;
          len_d    = bus.table_len;
          busy_d   = 1'b1;
          state_d  = (bus.table_len == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_PUSH;
      S_PUSH: begin
        if (!bus.i2c_fifo_full && (pending_q < MAX_PEND)) begin
          push     = 1'b1;
          issued_d = issued_q + LEN_ONE;
          if (last_entry) begin
            state_d = S_DRAIN;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        if (pend_after_comp == '0) begin
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A stalled bus overrides whatever the current state wanted, including a push.
    if (timeout) begin
      push     = 1'b0;
      idx_d    = idx_q;
      issued_d = issued_q;
      busy_d   = 1'b0;
      err_d    = 1'b1;
      state_d  = S_ERR;
    end
  end

  always_comb begin
    pending_d = pend_after_comp + 4'(push);
    if ((state_q == S_IDLE) && bus.start) begin
      pending_d = '0;
    end

    // Cleared by a completion, by pending=0 (which covers a push from zero) and outside a sequence.
    if (!busy_q || (pending_q == '0) || comp) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  assign din_d = push ? bus.table_data : din_q;

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      pending_q <= '0;
      timer_q   <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      wr_en_q   <= push;
      din_q     <= din_d;
    end
  end

  assign bus.table_addr     = idx_q;
  assign bus.i2c_fifo_din   = din_q;
  assign bus.i2c_fifo_wr_en = wr_en_q;
  assign bus.busy           = busy_q;
  assign bus.done           = (state_q == S_DONE) || (state_q == S_ERR);
  assign bus.err            = err_q;
  assign bus.issued_cnt     = issued_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Self-checking bench: directed scenarios plus randomized runs, checked against a
// transaction-level model (ordered word queue, outstanding count, completion schedule).
module tb_i2c_init_sequencer;

  localparam int AW    = 8;
  localparam int MAXP  = 2;
  localparam int LIMIT = 100 * 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  i2c_init_sequencer_if #(.TABLE_ADDR_WIDTH(AW)) ifc ();

  i2c_init_sequencer #(
    .CLK_FREQ_MHZ    (100),
    .TABLE_ADDR_WIDTH(AW),
    .MAX_PENDING     (MAXP),
    .TIMEOUT_US      (1)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [55:0] rom [256];
  logic [55:0] exp_q [$];
  int          due_q [$];
  logic [AW-1:0] addr_last = '0;

  int cyc = 0;
  int len_cur = 0;
  int pushes_seen = 0;
  int outstanding = 0;
  int completions = 0;
  int done_due = -1;
  int err_due = -1;
  int busy_from = -1;
  int busy_skip = -1;
  int due_last = 0;
  int dmin = 2;
  int dmax = 40;
  int full_mode = 0;
  bit busy_exp = 1'b0;
  bit err_exp = 1'b0;
  bit done_seen = 1'b0;
  bit comp_auto = 1'b0;
  bit manual_comp = 1'b0;
  bit stray_en = 1'b0;
  bit to_mode = 1'b0;
  bit full_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: sample outputs at the negedge, update the model, drive the next inputs.
  task automatic step();
    bit do_comp;
    int due;
    @(negedge clk);
    cyc++;
    if (cyc == err_due) begin
      err_exp     = 1'b1;
      outstanding = 0;
      due_q.delete();
    end
    if (cyc == busy_from) busy_exp = 1'b1;
    if (cyc == done_due)  busy_exp = 1'b0;
    check("done", 64'(ifc.done), 64'(cyc == done_due));
    check("err", 64'(ifc.err), 64'(err_exp));
    if (cyc != busy_skip) check("busy", 64'(ifc.busy), 64'(busy_exp));
    if (ifc.done) done_seen = 1'b1;

    if (ifc.i2c_fifo_wr_en === 1'b1) begin
      pushes_seen++;
      outstanding++;
      check("push_while_full", 64'(full_last), 64'(0));
      check("push_within_len", 64'(pushes_seen <= len_cur), 64'(1));
      if (exp_q.size() > 0) check("din", 64'(ifc.i2c_fifo_din), 64'(exp_q.pop_front()));
      check("pending_cap", 64'(outstanding <= MAXP), 64'(1));
      check("issued_cnt", 64'(ifc.issued_cnt), 64'(pushes_seen));
      if (to_mode && pushes_seen == 1) begin
        done_due = cyc + LIMIT;
        err_due  = cyc + LIMIT;
      end
      if (comp_auto) begin
        due = cyc + dmin + int'($urandom_range(0, dmax - dmin));
        if (due <= due_last) due = due_last + 1;
        due_last = due;
        due_q.push_back(due);
      end
    end

    ifc.table_data = rom[addr_last];
    addr_last      = ifc.table_addr;

    ifc.i2c_wr_data_success = 1'b0;
    ifc.i2c_rdata_valid     = 1'b0;
    do_comp = 1'b0;
    if (manual_comp) begin
      do_comp     = 1'b1;
      manual_comp = 1'b0;
    end else if (comp_auto && due_q.size() > 0 && due_q[0] <= cyc) begin
      do_comp = 1'b1;
      void'(due_q.pop_front());
    end else if (stray_en && outstanding == 0 && $urandom_range(0, 7) == 0) begin
      do_comp = 1'b1;
    end
    if (do_comp) begin
      if ($urandom_range(0, 1) == 0) ifc.i2c_wr_data_success = 1'b1;
      else                           ifc.i2c_rdata_valid     = 1'b1;
      if (outstanding > 0) begin
        outstanding--;
        completions++;
        if (completions == len_cur) done_due = cyc + 1;
      end
    end

    case (full_mode)
      1:       ifc.i2c_fifo_full = ($urandom_range(0, 3) == 0);
      2:       ifc.i2c_fifo_full = 1'b1;
      default: ifc.i2c_fifo_full = 1'b0;
    endcase
    full_last = ifc.i2c_fifo_full;
  endtask

  task automatic start_seq(input int len);
    ifc.start     = 1'b1;
    ifc.table_len = (AW+1)'(len);
    len_cur     = len;
    completions = 0;
    pushes_seen = 0;
    outstanding = 0;
    done_seen   = 1'b0;
    to_mode     = 1'b0;
    due_last    = 0;
    due_q.delete();
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(rom[i]);
    err_exp = 1'b0;
    err_due = -1;
    if (len == 0) begin
      done_due  = cyc + 1;
      busy_skip = cyc + 1;
    end else begin
      done_due  = -1;
      busy_from = cyc + 1;
    end
    step();
    ifc.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) step();
    check("done_reached", 64'(done_seen), 64'(1));
  endtask

  task automatic wait_pushes(input int n, input int budget);
    for (int i = 0; i < budget && pushes_seen < n; i++) step();
    check("pushes_reached", 64'(pushes_seen), 64'(n));
  endtask

  task automatic fill_rom(input int n);
    for (int i = 0; i < n; i++) rom[i] = 56'({$urandom(), $urandom()});
  endtask

  initial begin
    int c1;
    int len;
    ifc.start = 1'b0;
    ifc.table_len = '0;
    ifc.table_data = '0;
    ifc.i2c_fifo_full = 1'b0;
    ifc.i2c_wr_data_success = 1'b0;
    ifc.i2c_rdata_valid = 1'b0;
    fill_rom(256);

    // Reset state
    repeat (3) step();
    check("rst_wr_en", 64'(ifc.i2c_fifo_wr_en), 64'(0));
    check("rst_din", 64'(ifc.i2c_fifo_din), 64'(0));
    check("rst_issued", 64'(ifc.issued_cnt), 64'(0));
    check("rst_addr", 64'(ifc.table_addr), 64'(0));
    rstn = 1'b1;
    repeat (2) step();

    // Three words, each completed 50 cycles after its push
    comp_auto = 1'b1; dmin = 50; dmax = 50;
    start_seq(3);
    wait_done(400);
    check("t1_issued", 64'(ifc.issued_cnt), 64'(3));
    check("t1_pushes", 64'(pushes_seen), 64'(3));
    repeat (3) step();

    // Empty table
    start_seq(0);
    check("t2_done", 64'(done_seen), 64'(1));
    repeat (5) step();
    check("t2_no_push", 64'(pushes_seen), 64'(0));

    // Outstanding cap: no completions for 80 cycles
    comp_auto = 1'b0;
    start_seq(5);
    repeat (78) step();
    check("t3_capped", 64'(pushes_seen), 64'(MAXP));
    manual_comp = 1'b1;
    step();
    repeat (3) step();
    check("t3_release", 64'(pushes_seen), 64'(MAXP + 1));
    for (int i = 0; i < outstanding; i++) begin
      due_last = cyc + 3 * (i + 1);
      due_q.push_back(due_last);
    end
    comp_auto = 1'b1; dmin = 5; dmax = 15;
    wait_done(500);
    check("t3_issued", 64'(ifc.issued_cnt), 64'(5));
    repeat (3) step();

    // FIFO full held during entry 1
    comp_auto = 1'b1; dmin = 10; dmax = 10;
    start_seq(3);
    wait_pushes(1, 10);
    full_mode = 2;
    ifc.i2c_fifo_full = 1'b1;
    full_last = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      check("t4_held_wr_en", 64'(ifc.i2c_fifo_wr_en), 64'(0));
      check("t4_held_din", 64'(ifc.i2c_fifo_din), 64'(rom[0]));
    end
    full_mode = 0;
    step();
    check("t4_not_yet", 64'(pushes_seen), 64'(1));
    step();
    check("t4_push_after_full", 64'(pushes_seen), 64'(2));
    wait_done(300);
    repeat (3) step();

    // Timeout: no completion ever arrives
    comp_auto = 1'b0;
    start_seq(4);
    to_mode = 1'b1;
    wait_done(300);
    check("t5_issued", 64'(ifc.issued_cnt), 64'(MAXP));
    repeat (20) step();
    check("t5_no_more_push", 64'(pushes_seen), 64'(MAXP));

    // Next start clears err
    comp_auto = 1'b1; dmin = 5; dmax = 10;
    start_seq(2);
    wait_done(200);
    repeat (3) step();

    // Completion on the exact timeout cycle wins
    comp_auto = 1'b0;
    start_seq(2);
    wait_pushes(1, 10);
    c1 = cyc;
    for (int i = 0; i < 120 && cyc < c1 + LIMIT - 2; i++) step();
    manual_comp = 1'b1;
    step();
    repeat (20) step();
    manual_comp = 1'b1;
    step();
    step();
    check("t6_done", 64'(done_seen), 64'(1));
    repeat (3) step();

    // Reset while stalled in PUSH with two outstanding
    comp_auto = 1'b0;
    start_seq(5);
    wait_pushes(2, 20);
    repeat (3) step();
    rstn = 1'b0;
    #1;
    check("t7_busy", 64'(ifc.busy), 64'(0));
    check("t7_done", 64'(ifc.done), 64'(0));
    check("t7_wr_en", 64'(ifc.i2c_fifo_wr_en), 64'(0));
    check("t7_issued", 64'(ifc.issued_cnt), 64'(0));
    check("t7_din", 64'(ifc.i2c_fifo_din), 64'(0));
    outstanding = 0; busy_exp = 1'b0; busy_from = -1; err_exp = 1'b0;
    done_due = -1; err_due = -1;
    due_q.delete(); exp_q.delete();
    repeat (3) step();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      manual_comp = 1'b1;
      step();
      step();
    end
    check("t7_stray_ignored", 64'(ifc.issued_cnt), 64'(0));

    // Randomized runs with random FIFO-full, delays and stray completions
    for (int r = 0; r < 6; r++) begin
      len = int'($urandom_range(1, 12));
      fill_rom(len);
      comp_auto = 1'b1; dmin = 2; dmax = 40;
      full_mode = 1; stray_en = 1'b1;
      start_seq(len);
      wait_done(1500);
      check("rand_issued", 64'(ifc.issued_cnt), 64'(len));
      check("rand_pushes", 64'(pushes_seen), 64'(len));
      full_mode = 0;
      repeat (6) step();
      stray_en = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
- Walks a table of 56-bit I2C command words and pushes them, in order, into the command FIFO of the FIFO-fronted I2C master.
- Respects FIFO full and a cap on outstanding transactions.
- Counts completions, reported as write-success or read-data-valid pulses, until every entry has finished.
- Detects a stalled bus by timeout. Used for power-up configuration of on-board I2C devices before the application takes the bus.

Parameters:
CLK_FREQ_MHZ, 100, module clock frequency; scales the timeout.
TABLE_ADDR_WIDTH, 8, table index width; up to 2**TABLE_ADDR_WIDTH entries.
MAX_PENDING, 4, maximum commands pushed but not yet completed (1..15).
TIMEOUT_US, 20000, maximum gap between completions while commands are pending.

Ports:
clk  input  1  module clock
rstn  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a sequence when idle
table_len  input  TABLE_ADDR_WIDTH+1  entry count, sampled at start; 0 is legal
table_addr  output  TABLE_ADDR_WIDTH  table read address
table_data  input  56  table word; valid 1 cycle after table_addr (registered ROM/RAM)
i2c_fifo_din  output  56  command word to the I2C FIFO
i2c_fifo_wr_en  output  1  FIFO write strobe
i2c_fifo_full  input  1  FIFO full
i2c_wr_data_success  input  1  completion pulse, write
i2c_rdata_valid  input  1  completion pulse, read
busy  output  1  high from accepted start until done
done  output  1  1-cycle pulse at end of sequence (normal or error)
err  output  1  timeout flag; set with done, held until next accepted start
issued_cnt  output  TABLE_ADDR_WIDTH+1  commands pushed in the current or last sequence

Behaviour:
- Reset (async, rstn=0): state IDLE; all outputs 0; idx, pending and timer cleared. Reset mid-sequence abandons it silently: no done pulse, and FIFO contents are untouched.
- Command words are opaque. The word is copied from table_data to i2c_fifo_din unmodified.
- Completion event comp = i2c_wr_data_success | i2c_rdata_valid. Counted only when busy=1; ignored in IDLE.
- pending counter: +1 on push, -1 on comp, net 0 when both occur in the same cycle. A comp with pending=0 is ignored (no underflow).
- FSM:
  - IDLE: start and table_len=0 -> done=1 next cycle, err=0, remain IDLE (busy pulses 1 cycle). start and table_len>0 -> latch len, idx=0, issued_cnt=0, err=0, busy=1 -> FETCH. start while busy is ignored.
  - FETCH: table_addr=idx; next cycle -> PUSH (1-cycle read latency).
  - PUSH: hold table_addr. Push when !i2c_fifo_full and pending<MAX_PENDING: i2c_fifo_wr_en=1 for exactly one cycle, din=table_data, issued_cnt+1. Then if idx=len-1 -> DRAIN, else idx+1 -> FETCH. While stalled, wr_en stays 0 and the state is held.
  - DRAIN: wait for pending=0 -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
  - ERR: done=1, err=1, busy=0 -> IDLE. No further pushes occur.
- i2c_fifo_wr_en is registered; din is valid in the same cycle as wr_en. Throughput is at most one push per 2 cycles.
- Timeout:
  - Counter runs while busy and pending>0; cleared on comp, on a push-from-zero, and whenever pending=0.
  - Limit = CLK_FREQ_MHZ*TIMEOUT_US cycles; counter width is sized for the limit.
  - Reaching the limit in any state -> ERR. Commands already in the FIFO are not flushed.
- A comp arriving in the same cycle as the timeout limit takes precedence: the timer clears and there is no error.

Test Plan:
- table_len=3, words A/B/C, each comp 50 cycles after its push, MAX_PENDING=4 -> wr_en pulses carry A,B,C in order; done 1 cycle after the 3rd comp; err=0; issued_cnt=3.
- table_len=0, start -> done pulse next cycle, wr_en never asserted, err=0.
- MAX_PENDING=2, table_len=5, no comps until cycle 200 -> exactly 2 pushes before cycle 200; each comp releases one more push; all 5 complete and done is asserted.
- i2c_fifo_full held high 30 cycles during entry 1 -> wr_en held low, din unchanged; push occurs the cycle after full drops; order preserved.
- TIMEOUT_US=1, CLK_FREQ_MHZ=100, no comp after first push -> ERR after 100 cycles: done=1, err=1, no further wr_en; next start clears err.
- rstn asserted mid-PUSH with pending=2 -> outputs 0 immediately; no done pulse; stray comps after reset ignored; a fresh start works normally.
